// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master controller.
// Holds the FSM state enum, quarter-phase codes and bus ACK/NACK levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_STRT,
        S_ADDR,
        S_AACK,
        S_WBYTE,
        S_WACK,
        S_RBYTE,
        S_RACK,
        S_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// i2c_master_ctrl_if: command, data and I2C pin bundle of the controller.
// master = controller side, slave = host/bus-model side.
interface i2c_master_ctrl_if;

    logic       iSDA;
    logic       START;
    logic [6:0] ADDR;
    logic       RW;
    logic [2:0] NBYTES;
    logic [7:0] TX_DATA;
    logic       TX_LOAD;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       SCL;
    logic       oSDA;
    logic       BUSY;
    logic       DONE;
    logic       NACK;

    modport master (
        input  iSDA, START, ADDR, RW, NBYTES, TX_DATA,
        output TX_LOAD, RX_DATA, RX_VALID, SCL, oSDA, BUSY, DONE, NACK
    );

    modport slave (
        output iSDA, START, ADDR, RW, NBYTES, TX_DATA,
        input  TX_LOAD, RX_DATA, RX_VALID, SCL, oSDA, BUSY, DONE, NACK
    );

endinterface

// File: rtl/i2c_qtr_timer.sv
// i2c_qtr_timer: divides CLK into SCL quarter-bit ticks.
// Ports: CLK, RESET_N, i_en (count), i_clr (sync clear), o_tick (last cycle).
module i2c_qtr_timer #(
    parameter int QTR_CYC = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [7:0] LAST = 8'(QTR_CYC - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: I2C master issuing START, address+RW, 0..7 data bytes, STOP.
// Ports: CLK, RESET_N (async active-low), bus (i2c_master_ctrl_if.master).
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int QTR_CYC = 2
) (
    input logic               CLK,
    input logic               RESET_N,
    i2c_master_ctrl_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_q;
    logic [2:0] r_bit;
    logic [2:0] r_left;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_sda_s;
    logic       r_nack;
    logic       r_done;
    logic [7:0] r_rx;
    logic       r_rxv;

    logic       w_tick;
    logic       w_run;
    logic       w_busy;
    logic       w_accept;
    logic       w_slot_end;
    logic       w_q2_end;
    logic       w_last_bit;
    logic       w_hi;
    logic       w_scl;
    logic       w_sda;
    logic       w_txld;

    // r_done keeps BUSY up through the DONE cycle so a new START waits.
    assign w_busy     = (r_state != S_IDLE) || r_done;
    assign w_accept   = (r_state == S_IDLE) && bus.START && !w_busy;
    assign w_run      = (r_state != S_IDLE);
    assign w_slot_end = w_tick && (r_q == Q3);
    assign w_q2_end   = w_tick && (r_q == Q2);
    assign w_last_bit = w_slot_end && (r_bit == 3'd7);
    assign w_hi       = (r_q == Q2) || (r_q == Q3);

    i2c_qtr_timer #(
        .QTR_CYC (QTR_CYC)
    ) u_tmr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_en    (w_run),
        .i_clr   (w_accept),
        .o_tick  (w_tick)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_scl  = 1'b1;
        w_sda  = 1'b1;
        w_txld = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_STRT;
            end
            S_STRT: begin
                w_sda = (r_q == Q0) || (r_q == Q1);
                if (w_slot_end) w_next = S_ADDR;
            end
            S_ADDR: begin
                w_scl = w_hi;
                w_sda = r_shift[7];
                if (w_last_bit) w_next = S_AACK;
            end
            S_AACK, S_WACK: begin
                w_scl = w_hi;
                if (w_slot_end) begin
                    if (r_sda_s == NACK_LVL || r_left == 3'd0) begin
                        w_next = S_STOP;
                    end else if (r_rw) begin
                        w_next = S_RBYTE;
                    end else begin
                        w_next = S_WBYTE;
                        w_txld = 1'b1;
                    end
                end
            end
            S_WBYTE: begin
                w_scl = w_hi;
                w_sda = r_shift[7];
                if (w_last_bit) w_next = S_WACK;
            end
            S_RBYTE: begin
                w_scl = w_hi;
                if (w_last_bit) w_next = S_RACK;
            end
            S_RACK: begin
                w_scl = w_hi;
                // r_left is already decremented for the byte just read.
                w_sda = (r_left == 3'd0) ? NACK_LVL : ACK_LVL;
                if (w_slot_end) begin
                    w_next = (r_left == 3'd0) ? S_STOP : S_RBYTE;
                end
            end
            S_STOP: begin
                w_scl = w_hi;
                w_sda = (r_q == Q3);
                if (w_slot_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_q     <= Q0;
            r_bit   <= 3'd0;
            r_left  <= 3'd0;
            r_shift <= 8'h00;
            r_rw    <= 1'b0;
            r_sda_s <= 1'b1;
            r_nack  <= 1'b0;
            r_done  <= 1'b0;
            r_rx    <= 8'h00;
            r_rxv   <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && w_slot_end;
            r_rxv  <= 1'b0;

            if (w_accept) begin
                r_q    <= Q0;
                r_bit  <= 3'd0;
                r_left <= bus.NBYTES;
                r_rw   <= bus.RW;
                r_nack <= 1'b0;
            end else begin
                if (w_tick) r_q <= r_q + 2'd1;
                if (w_slot_end && (r_state == S_ADDR || r_state == S_WBYTE
                                   || r_state == S_RBYTE)) begin
                    r_bit <= r_bit + 3'd1;
                end
                if (w_last_bit && (r_state == S_WBYTE || r_state == S_RBYTE)
                    && r_left != 3'd0) begin
                    r_left <= r_left - 3'd1;
                end
                if (w_slot_end && (r_state == S_AACK || r_state == S_WACK)
                    && r_sda_s == NACK_LVL) begin
                    r_nack <= 1'b1;
                end
            end

            if (w_q2_end) r_sda_s <= bus.iSDA;

            if (w_accept) begin
                r_shift <= {bus.ADDR, bus.RW};
            end else if (w_txld) begin
                r_shift <= bus.TX_DATA;
            end else if (w_slot_end && (r_state == S_ADDR || r_state == S_WBYTE)) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end else if (w_q2_end && r_state == S_RBYTE) begin
                r_shift <= {r_shift[6:0], bus.iSDA};
            end

            if (w_last_bit && r_state == S_RBYTE) begin
                r_rx  <= r_shift;
                r_rxv <= 1'b1;
            end
        end
    end

    assign bus.SCL      = w_scl;
    assign bus.oSDA     = w_sda;
    assign bus.TX_LOAD  = w_txld;
    assign bus.BUSY     = w_busy;
    assign bus.DONE     = r_done;
    assign bus.NACK     = r_nack;
    assign bus.RX_DATA  = r_rx;
    assign bus.RX_VALID = r_rxv;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed bench for i2c_master_ctrl at QTR_CYC=2.
// A per-slot slave model drives iSDA; SDA is captured on every SCL rise.
module tb_i2c_master_ctrl;

    localparam int SLOT = 8;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;

    int nchk = 0;
    int nerr = 0;

    int         done_cyc;
    int         nbits;
    int         ntx;
    int         nrx;
    logic       nack_done;
    logic       bits [64];
    logic [7:0] rx   [4];

    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(
        .QTR_CYC (2)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = bits[idx+i];
        return v;
    endfunction

    // Slot map: 0 STRT, 1-8 ADDR, 9 AACK, then 9 slots per data byte.
    function automatic logic slave_bit(input int s, input logic rw, input logic ack,
                                       input logic [7:0] b0, input logic [7:0] b1);
        int j;
        int k;
        if (!ack) return 1'b1;
        if (s == 9) return 1'b0;
        if (s < 10) return 1'b1;
        j = (s - 10) % 9;
        k = (s - 10) / 9;
        if (j == 8) return rw;
        if (!rw) return 1'b1;
        return (k == 0) ? b0[7-j] : b1[7-j];
    endfunction

    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [2:0] nb,
                           input logic [7:0] b0, input logic [7:0] b1, input logic ack,
                           input int ghost_at, input int abort_at);
        logic prev_scl;
        done_cyc  = -1;
        nbits     = 0;
        ntx       = 0;
        nrx       = 0;
        nack_done = 1'bx;
        for (int i = 0; i < 64; i++) bits[i] = 1'b0;
        bus.ADDR    = a;
        bus.RW      = rw;
        bus.NBYTES  = nb;
        bus.TX_DATA = b0;
        bus.iSDA    = 1'b1;
        bus.START   = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        chk("busy_after_accept", bus.BUSY, 1'b1);
        prev_scl = 1'b1;
        for (int n = 0; n <= 400; n++) begin
            if (bus.SCL && !prev_scl && nbits < 64) begin
                bits[nbits] = bus.oSDA;
                nbits++;
            end
            prev_scl = bus.SCL;
            if (bus.DONE) begin
                done_cyc  = n;
                nack_done = bus.NACK;
                break;
            end
            if (n == abort_at) begin
                chk("pre_reset_scl", bus.SCL, 1'b0);
                chk("pre_reset_sda", bus.oSDA, 1'b0);
                RESET_N = 1'b0;
                #1;
                return;
            end
            bus.TX_DATA = (ntx > 0) ? b1 : b0;
            if (bus.TX_LOAD) ntx++;
            if (bus.RX_VALID) begin
                if (nrx < 4) rx[nrx] = bus.RX_DATA;
                nrx++;
            end
            bus.iSDA  = slave_bit(n / SLOT, rw, ack, b0, b1);
            bus.START = (n == ghost_at);
            if (n == ghost_at) begin
                bus.ADDR   = ~a;
                bus.NBYTES = 3'd7;
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        bus.iSDA    = 1'b1;
        bus.START   = 1'b0;
        bus.ADDR    = 7'h00;
        bus.RW      = 1'b0;
        bus.NBYTES  = 3'd0;
        bus.TX_DATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_scl", bus.SCL, 1'b1);
        chk("rst_sda", bus.oSDA, 1'b1);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_done", bus.DONE, 1'b0);
        chk("rst_nack", bus.NACK, 1'b0);
        chk("rst_txld", bus.TX_LOAD, 1'b0);
        chk("rst_rxv", bus.RX_VALID, 1'b0);
        chk("rst_rxd", bus.RX_DATA, 8'h00);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Read, no data, slave ACKs address.
        run_txn(7'h02, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, -1, -1);
        chk("a_addr", byte_at(0), 8'h05);
        chk("a_aack_rel", bits[8], 1'b1);
        chk("a_stop", bits[9], 1'b0);
        chk("a_nbits", nbits, 10);
        chk("a_done", done_cyc, 88);
        chk("a_nack", nack_done, 1'b0);
        chk("a_tx", ntx, 0);
        chk("a_rx", nrx, 0);
        chk("a_idle_busy", bus.BUSY, 1'b0);

        // Address NACK goes straight to STOP.
        run_txn(7'h7F, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, -1, -1);
        chk("b_addr", byte_at(0), 8'hFF);
        chk("b_done", done_cyc, 88);
        chk("b_nack", nack_done, 1'b1);
        chk("b_tx", ntx, 0);
        chk("b_rx", nrx, 0);
        chk("b_nack_sticky", bus.NACK, 1'b1);

        // Two-byte write.
        run_txn(7'h50, 1'b0, 3'd2, 8'hA5, 8'h3C, 1'b1, -1, -1);
        chk("c_addr", byte_at(0), 8'hA0);
        chk("c_byte0", byte_at(9), 8'hA5);
        chk("c_wack0", bits[17], 1'b1);
        chk("c_byte1", byte_at(18), 8'h3C);
        chk("c_wack1", bits[26], 1'b1);
        chk("c_stop", bits[27], 1'b0);
        chk("c_tx", ntx, 2);
        chk("c_done", done_cyc, 232);
        chk("c_nack", nack_done, 1'b0);

        // Two-byte read.
        run_txn(7'h21, 1'b1, 3'd2, 8'h96, 8'h0F, 1'b1, -1, -1);
        chk("d_addr", byte_at(0), 8'h43);
        chk("d_rbyte_rel", byte_at(9), 8'hFF);
        chk("d_rack0", bits[17], 1'b0);
        chk("d_rack1", bits[26], 1'b1);
        chk("d_nrx", nrx, 2);
        chk("d_rx0", rx[0], 8'h96);
        chk("d_rx1", rx[1], 8'h0F);
        chk("d_tx", ntx, 0);
        chk("d_done", done_cyc, 232);
        chk("d_rx_hold", bus.RX_DATA, 8'h0F);

        // START while busy with different ADDR/NBYTES is ignored.
        run_txn(7'h02, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 20, -1);
        chk("e_addr", byte_at(0), 8'h05);
        chk("e_done", done_cyc, 88);
        chk("e_nbits", nbits, 10);

        // Reset in the 4th write-data slot.
        run_txn(7'h50, 1'b0, 3'd2, 8'hA5, 8'h3C, 1'b1, -1, 106);
        chk("f_scl", bus.SCL, 1'b1);
        chk("f_sda", bus.oSDA, 1'b1);
        chk("f_busy", bus.BUSY, 1'b0);
        chk("f_done", bus.DONE, 1'b0);
        chk("f_txld", bus.TX_LOAD, 1'b0);
        chk("f_rxd", bus.RX_DATA, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        run_txn(7'h50, 1'b0, 3'd2, 8'hA5, 8'h3C, 1'b1, -1, -1);
        chk("g_addr", byte_at(0), 8'hA0);
        chk("g_byte0", byte_at(9), 8'hA5);
        chk("g_byte1", byte_at(18), 8'h3C);
        chk("g_tx", ntx, 2);
        chk("g_done", done_cyc, 232);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter QTR_CYC, default 2: CLK cycles per SCL quarter-bit; legal range 1..255.
REQ-002 CLK  in  1  system clock; all logic rising-edge.
REQ-003 RESET_N  in  1  one clock; reset is asynchronous and active-low.
REQ-004 iSDA  in  1  sampled SDA bus level.
REQ-005 START  in  1  transaction request; accepted only while BUSY=0.
REQ-006 ADDR  in  7  target address; captured at accept.
REQ-007 RW  in  1  0=write, 1=read; captured at accept.
REQ-008 NBYTES  in  3  data bytes after address, 0..7; captured at accept.
REQ-009 TX_DATA  in  8  next write byte; captured when TX_LOAD=1.
REQ-010 TX_LOAD  out  1  one-cycle pulse: TX_DATA consumed this cycle.
REQ-011 RX_DATA  out  8  last received byte; held until next RX_VALID.
REQ-012 RX_VALID  out  1  one-cycle pulse: RX_DATA updated.
REQ-013 SCL  out  1  I2C clock.
REQ-014 oSDA  out  1  SDA drive value; 1 = release (open-drain).
REQ-015 BUSY  out  1  high from cycle after accept through DONE cycle.
REQ-016 DONE  out  1  one-cycle pulse at transaction end.
REQ-017 NACK  out  1  sticky; set on slave NACK; cleared at next accept.

Function
REQ-018 States SHALL be IDLE, STRT, ADDR, AACK, WBYTE, WACK, RBYTE, RACK, STOP.
REQ-019 Each bit slot SHALL be 4 quarters of QTR_CYC cycles: q0,q1 SCL=0; q2,q3 SCL=1; oSDA changes only at q0 entry.
REQ-020 iSDA SHALL be sampled on the last cycle of q2.
REQ-021 IDLE: SCL=1, oSDA=1; START=1 -> STRT next cycle, BUSY=1, NACK cleared.
REQ-022 STRT: SCL=1 whole slot; oSDA=1 for q0-q1, 0 for q2-q3; then ADDR.
REQ-023 ADDR: shift {ADDR,RW} MSB first, 8 slots; then AACK with oSDA=1.
REQ-024 AACK sampled iSDA=1 -> NACK=1, go STOP; else NBYTES=0 -> STOP, RW=0 -> WBYTE, RW=1 -> RBYTE.
REQ-025 TX_LOAD SHALL pulse in the final cycle of AACK/WACK whenever the next state is WBYTE.
REQ-026 WBYTE: 8 slots MSB first; WACK releases SDA; iSDA=1 -> NACK=1, STOP; else remaining bytes>0 -> WBYTE, else STOP.
REQ-027 RBYTE: oSDA=1, shift iSDA MSB first; RX_DATA update and RX_VALID pulse at end of 8th slot.
REQ-028 RACK: oSDA=0 if bytes remain, 1 on last byte; then RBYTE or STOP.
REQ-029 STOP: q0-q1 SCL=0 oSDA=0; q2 SCL=1 oSDA=0; q3 SCL=1 oSDA=1; DONE pulses in the following cycle, returning to IDLE.
REQ-030 START while BUSY=1 SHALL be ignored, with no effect on captured fields.
REQ-031 Byte counter SHALL decrement per data byte; no wrap below 0.
REQ-032 Transaction length SHALL be (2+9*(1+NBYTES))*4*QTR_CYC cycles from STRT entry to DONE, absent NACK.

Reset
REQ-033 RESET_N=0 SHALL immediately force IDLE, SCL=1, oSDA=1, BUSY=0, DONE=0, NACK=0, TX_LOAD=0, RX_VALID=0, RX_DATA=8'h00, all counters 0.
REQ-034 Reset mid-transaction SHALL abort with no STOP generated; first START after release behaves as from power-up.

Structure
REQ-035 Shared package i2c_pkg SHALL hold the state enumeration, quarter-phase constants Q0..Q3, and the ACK/NACK level constants.
REQ-036 Quarter-tick generation SHALL live in sub-module i2c_qtr_timer (counter 0..QTR_CYC-1, tick output, synchronous clear at accept).

Verification
REQ-037 QTR_CYC=2, ADDR=7'h02, RW=1, NBYTES=0, iSDA=0 at AACK -> SDA bits 0,0,0,0,0,1,0,1; DONE at cycle 88; NACK=0.
REQ-038 ADDR=7'h7F, RW=1, iSDA held 1 -> NACK=1 after AACK, STOP follows directly, DONE at cycle 88, no TX_LOAD/RX_VALID.
REQ-039 Write NBYTES=2, TX_DATA 8'hA5 then 8'h3C, slave ACKs -> two TX_LOAD pulses, SDA shows A5 then 3C MSB first, DONE at cycle 232.
REQ-040 Read NBYTES=2, slave drives 8'h96 then 8'h0F -> RX_VALID twice with those values; master ACK=0 first, 1 second.
REQ-041 RESET_N low during 4th WBYTE slot -> same cycle SCL=1, oSDA=1, BUSY=0; next START yields full normal transaction.
REQ-042 START pulsed while BUSY=1 with different ADDR -> ignored; transaction completes using original ADDR.
